led_matrix_scan_ctrl: RTL and testbench
=======================================

Name: led_matrix_scan_ctrl

Overview:
- Drive side of the 16x16 LED matrix column/row interface: sequences the column select, generates a one-hot column enable with a blanking gap, and presents the 16-bit row pattern for the active column.
- Holds a double-buffered 16x16 frame store, so upstream logic can compose a frame while the previous one is displayed.
- The back buffer becomes the displayed buffer only at a frame boundary, on request.

Parameters:
- DWELL, 1000: clock cycles per column, blank plus show; legal range 2..65535.
- BLANK, 16: cycles at the start of each column during which all columns and rows are off; legal range 0..DWELL-1.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write one column word into the back buffer.
- wr_col  in  4  column index for the write.
- wr_data  in  16  row bits for that column; bit i is row i.
- swap_req  in  1  request a front/back swap at the next frame boundary.
- swap_ack  out  1  one-cycle pulse in the cycle the swap takes effect.
- frame_start  out  1  one-cycle pulse in the first cycle of column 0.
- col_sel  out  4  index of the column currently being scanned.
- col_en  out  16  one-hot column enable; all zero during blanking.
- row  out  16  row pattern for col_sel; all zero during blanking.

Behaviour:
- Reset (synchronous, active-high):
  - col_sel=0, col_en=0, row=0, swap_ack=0, frame_start=0.
  - Dwell counter=0, front-bank index=0, swap pending=0, FSM=BLANK.
  - Both banks are cleared to zero.
- First frame: the first cycle after rst deasserts is cycle 0 of column 0, and frame_start=1 in that cycle.
- All outputs are registered.
- Dwell counter cnt runs 0..DWELL-1 per column. When cnt=DWELL-1, cnt wraps to 0 and col_sel increments mod 16 (15 wraps to 0).
- FSM states:
  - BLANK: active while cnt<BLANK. col_en=0, row=0.
  - SHOW: active while cnt>=BLANK. col_en=1<<col_sel, row=front[col_sel].
  - When BLANK=0, the BLANK state is never entered.
- Row data is read from the front bank on entry to SHOW and held for the rest of the column.
- A frame is exactly 16*DWELL cycles. frame_start pulses when col_sel=0 and cnt=0.
- Writes:
  - When wr_en=1, back[wr_col] is updated at the clock edge.
  - The back bank is selected by the front-bank index as it stands before that edge.
  - Writes never change the displayed image within the current frame.
- Swap handshake:
  - swap_req=1 sets pending.
  - At the frame boundary (col_sel=15, cnt=DWELL-1 → col_sel=0, cnt=0), if pending is set: the front index toggles, pending clears, and swap_ack=1 in the same cycle as frame_start.
  - swap_req while already pending has no additional effect; at most one swap per frame.
  - swap_req asserted in the boundary cycle itself counts for the next frame, not this one.
- Simultaneous write and swap at the boundary: the write lands in the old back bank, which becomes front in the cycle that follows the edge. The new frame therefore shows that write.
- The swap does not copy data. The new back bank holds the previous front image.
- rst asserted mid-frame: full reset at the next edge. Pending requests and both bank contents are discarded.

Decomposition:
- Shared package led_matrix_pkg holds:
  - N_COLS=16, N_ROWS=16.
  - col_idx_t (4 bits) and row_word_t (16 bits).
  - The one-hot decode function, shared with the Scanner side.
- One sub-module, led_frame_bank2:
  - Dual 16x16 register bank with write port, read port and bank toggle.
  - Owns the clear-on-reset and the front index.
- The scan counter and FSM stay in the top module.

Test Plan (DWELL=4, BLANK=1 unless stated):
- Reset then idle 64 cycles:
  - frame_start at cycles 0 and 64.
  - col_sel steps 0..15 every 4 cycles.
  - col_en=0 in cycle 0 of each column, then 1<<col_sel for 3 cycles.
  - row=0 throughout.
- Write col 3 = 16'hA5A5 with no swap: row stays 0 for the full frame, and after the next frame as well.
- Write col 3 = 16'hA5A5, pulse swap_req at cycle 10:
  - swap_ack and frame_start both pulse at cycle 64.
  - row=16'hA5A5 during cycles 77..79 (col 3 SHOW).
  - swap_ack is 0 at cycle 128.
- swap_req held high 3 frames: exactly one swap_ack per boundary. The displayed image alternates between the two banks.
- Write col 0 = 16'h0001 and swap_req in the boundary cycle 63: no swap at 64, the swap happens at 128, and row=16'h0001 at cycles 129..131.
- BLANK=0, DWELL=2: col_en is never 0 after reset. Then assert rst mid-frame at cycle 37: at the next edge all outputs are 0 and col_sel=0, and the sequence restarts.

Source files
------------

// File: rtl/led_matrix_scan_ctrl_pkg.sv
// Shared types and helpers for the 16x16 LED matrix scan controller.
// Column/row widths and the column one-hot decode live here so every side agrees on them.
package led_matrix_pkg;

    localparam int N_COLS = 16;
    localparam int N_ROWS = 16;

    typedef logic [3:0]        col_idx_t;
    typedef logic [N_ROWS-1:0] row_word_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic logic [N_COLS-1:0] col_onehot(input col_idx_t col);
        logic [N_COLS-1:0] v;
        v      = '0;
        v[col] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Frame-write/swap handshake plus the column/row drive bundle of the LED matrix controller.
// The host side (master) composes frames; the scanner (slave) drives the matrix.
interface led_matrix_scan_ctrl_if import led_matrix_pkg::*; ;

    logic              wr_en;
    col_idx_t          wr_col;
    row_word_t         wr_data;
    logic              swap_req;
    logic              swap_ack;
    logic              frame_start;
    col_idx_t          col_sel;
    logic [N_COLS-1:0] col_en;
    row_word_t         row;

    modport master (
        output wr_en, wr_col, wr_data, swap_req,
        input  swap_ack, frame_start, col_sel, col_en, row
    );

    modport slave (
        input  wr_en, wr_col, wr_data, swap_req,
        output swap_ack, frame_start, col_sel, col_en, row
    );

endinterface

// File: rtl/led_matrix_scan_ctrl_bank2.sv
// Double-buffered 16x16 frame store: writes go to the back bank, reads come from the front bank.
// Owns the front index and clears both banks on reset.
module led_frame_bank2 import led_matrix_pkg::*; (
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  col_idx_t  wr_col,
    input  row_word_t wr_data,
    input  logic      toggle,
    input  col_idx_t  rd_col,
    output row_word_t rd_data
);

    row_word_t mem_q [2][N_COLS];
    row_word_t mem_d [2][N_COLS];
    logic      front_q;
    logic      front_d;
    logic      back_idx;

    always_comb begin
        mem_d    = mem_q;
        back_idx = ~front_q;
        if (wr_en) begin
            mem_d[back_idx][wr_col] = wr_data;
        end
        front_d = front_q ^ toggle;
        // Read the post-edge view so a write landing at the swap edge is visible immediately.
        rd_data = mem_d[front_d][rd_col];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            front_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            front_q <= front_d;
        end
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Column scanner for the 16x16 LED matrix: dwell counter, blank/show FSM and swap handshake.
// cnt_q/col_q hold the position of the next output cycle; every output is registered from them.
module led_matrix_scan_ctrl import led_matrix_pkg::*; #(
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    led_matrix_scan_ctrl_if.slave  bus
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [16:0] BLANK_W    = 17'(BLANK);

    logic [15:0]       cnt_q, cnt_d;
    col_idx_t          col_q, col_d;
    col_idx_t          col_sel_q, col_sel_d;
    logic [N_COLS-1:0] col_en_q, col_en_d;
    row_word_t         row_q, row_d;
    logic              frame_start_q, frame_start_d;
    logic              swap_ack_q, swap_ack_d;
    logic              pending_q, pending_d;
    scan_state_t       state_q, state_d;
    logic              col_last;
    logic              do_swap;
    row_word_t         rd_data;

    led_frame_bank2 u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .toggle  (do_swap),
        .rd_col  (col_q),
        .rd_data (rd_data)
    );

    always_comb begin
        col_last      = (cnt_q == DWELL_LAST);
        cnt_d         = col_last ? '0 : cnt_q + 16'd1;
        col_d         = col_last ? col_q + 4'd1 : col_q;
        frame_start_d = (cnt_q == '0) && (col_q == '0);
        // A request seen in the boundary cycle only arms the following frame.
        do_swap       = frame_start_d & pending_q;
        pending_d     = bus.swap_req | (pending_q & ~do_swap);
        swap_ack_d    = do_swap;
        col_sel_d     = col_q;
        state_d       = (({1'b0, cnt_q} + 17'd1) <= BLANK_W) ? ST_BLANK : ST_SHOW;
        col_en_d      = '0;
        row_d         = '0;
        if (state_d == ST_SHOW) begin
            col_en_d = col_onehot(col_q);
            row_d    = (state_q == ST_BLANK || cnt_q == '0) ? rd_data : row_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            col_q         <= '0;
            col_sel_q     <= '0;
            col_en_q      <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            pending_q     <= 1'b0;
            state_q       <= ST_BLANK;
        end else begin
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            col_sel_q     <= col_sel_d;
            col_en_q      <= col_en_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
            swap_ack_q    <= swap_ack_d;
            pending_q     <= pending_d;
            state_q       <= state_d;
        end
    end

    assign bus.col_sel     = col_sel_q;
    assign bus.col_en      = col_en_q;
    assign bus.row         = row_q;
    assign bus.frame_start = frame_start_q;
    assign bus.swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: two instances (DWELL=4/BLANK=1 and DWELL=2/BLANK=0)
// checked every cycle against a cycle-index model, plus literal spot checks.
module tb_led_matrix_scan_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    led_matrix_scan_ctrl_if a_if ();
    led_matrix_scan_ctrl_if b_if ();

    led_matrix_scan_ctrl #(.DWELL(4), .BLANK(1)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    led_matrix_scan_ctrl #(.DWELL(2), .BLANK(0)) dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));

    // model state, index 0 = dut_a, 1 = dut_b
    int          dw [2] = '{4, 2};
    int          bl [2] = '{1, 0};
    bit          m_valid [2] = '{1'b0, 1'b0};
    int          m_t [2];
    int          m_front [2];
    bit          m_pend [2];
    logic [15:0] m_bank [2][2][16];
    logic        e_fs [2];
    logic        e_ack [2];
    logic [3:0]  e_col [2];
    logic [15:0] e_en [2];
    logic [15:0] e_row [2];

    task automatic model_step(input int i, input logic r, input logic we, input logic [3:0] wc,
                              input logic [15:0] wd, input logic sr);
        int pos, col, c;
        bit sw;
        if (r) begin
            m_valid[i] = 1'b1;
            m_t[i]     = -1;
            m_front[i] = 0;
            m_pend[i]  = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 16; k++) m_bank[i][b][k] = '0;
            e_fs[i] = 1'b0; e_ack[i] = 1'b0; e_col[i] = '0; e_en[i] = '0; e_row[i] = '0;
        end else if (m_valid[i]) begin
            m_t[i] = m_t[i] + 1;
            pos = m_t[i] % (16 * dw[i]);
            col = pos / dw[i];
            c   = pos % dw[i];
            sw  = (pos == 0) && m_pend[i];
            if (we) m_bank[i][1 - m_front[i]][wc] = wd;
            if (sw) m_front[i] = 1 - m_front[i];
            m_pend[i] = sr || (m_pend[i] && !sw);
            e_fs[i]  = (pos == 0);
            e_ack[i] = sw;
            e_col[i] = 4'(col);
            if (c < bl[i]) begin
                e_en[i]  = '0;
                e_row[i] = '0;
            end else begin
                e_en[i]  = 16'd1 << col;
                e_row[i] = m_bank[i][m_front[i]][col];
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, a_if.wr_en, a_if.wr_col, a_if.wr_data, a_if.swap_req);
        model_step(1, rst_b, b_if.wr_en, b_if.wr_col, b_if.wr_data, b_if.swap_req);
    end

    task automatic cmp(input int i, input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d cyc=%0d %s got=%h want=%h", i, m_t[i], nm, act, exp);
        end
    endtask

    task automatic check_out(input int i, input logic fs, input logic ack, input logic [3:0] cs,
                             input logic [15:0] en, input logic [15:0] rw);
        cmp(i, "frame_start", 16'(fs), 16'(e_fs[i]));
        cmp(i, "swap_ack", 16'(ack), 16'(e_ack[i]));
        cmp(i, "col_sel", 16'(cs), 16'(e_col[i]));
        cmp(i, "col_en", en, e_en[i]);
        cmp(i, "row", rw, e_row[i]);
    endtask

    always @(negedge clk) begin
        if (m_valid[0]) check_out(0, a_if.frame_start, a_if.swap_ack, a_if.col_sel, a_if.col_en, a_if.row);
        if (m_valid[1]) check_out(1, b_if.frame_start, b_if.swap_ack, b_if.col_sel, b_if.col_en, b_if.row);
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL lit %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic goto_a(input int n);
        for (int k = 0; k < 2000 && m_t[0] != n; k++) @(negedge clk);
        if (m_t[0] != n) begin
            total++;
            bad++;
            $display("FAIL goto cycle %0d got=%0d want=%0d", n, m_t[0], n);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lit("rst col_sel", 32'(a_if.col_sel), 32'h0);
        lit("rst col_en", 32'(a_if.col_en), 32'h0);
        lit("rst row", 32'(a_if.row), 32'h0);
        lit("rst frame_start", 32'(a_if.frame_start), 32'h0);
        lit("rst swap_ack", 32'(a_if.swap_ack), 32'h0);
        rst_a = 1'b0;
    endtask

    task automatic wr_a(input logic [3:0] col, input logic [15:0] data);
        a_if.wr_en   = 1'b1;
        a_if.wr_col  = col;
        a_if.wr_data = data;
        @(negedge clk);
        a_if.wr_en   = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.wr_en = 1'b0; a_if.wr_col = '0; a_if.wr_data = '0; a_if.swap_req = 1'b0;
        b_if.wr_en = 1'b0; b_if.wr_col = '0; b_if.wr_data = '0; b_if.swap_req = 1'b0;

        // idle scan, plus mid-frame reset of the BLANK=0 instance
        reset_a();
        rst_b = 1'b0;
        goto_a(0);  lit("c0 frame_start", 32'(a_if.frame_start), 32'h1);
                    lit("c0 col_en", 32'(a_if.col_en), 32'h0);
        goto_a(1);  lit("c1 col_en", 32'(a_if.col_en), 32'h0001);
        goto_a(4);  lit("c4 col_sel", 32'(a_if.col_sel), 32'h1);
                    lit("c4 col_en", 32'(a_if.col_en), 32'h0);
        goto_a(5);  lit("c5 col_en", 32'(a_if.col_en), 32'h0002);
        goto_a(37);
        rst_b = 1'b1;
        @(negedge clk);
        lit("b rst col_sel", 32'(b_if.col_sel), 32'h0);
        lit("b rst col_en", 32'(b_if.col_en), 32'h0);
        lit("b rst frame_start", 32'(b_if.frame_start), 32'h0);
        rst_b = 1'b0;
        @(negedge clk);
        lit("b restart frame_start", 32'(b_if.frame_start), 32'h1);
        lit("b restart col_en", 32'(b_if.col_en), 32'h0001);
        goto_a(63); lit("c63 col_sel", 32'(a_if.col_sel), 32'hF);
                    lit("c63 col_en", 32'(a_if.col_en), 32'h8000);
        goto_a(64); lit("c64 frame_start", 32'(a_if.frame_start), 32'h1);
                    lit("c64 col_sel", 32'(a_if.col_sel), 32'h0);

        // write without swap stays invisible
        reset_a();
        goto_a(2);  wr_a(4'd3, 16'hA5A5);
        goto_a(78); lit("noswap row f1", 32'(a_if.row), 32'h0);
        goto_a(142); lit("noswap row f2", 32'(a_if.row), 32'h0);

        // write then single swap request
        reset_a();
        goto_a(2);  wr_a(4'd3, 16'hA5A5);
        goto_a(10); a_if.swap_req = 1'b1;
        @(negedge clk); a_if.swap_req = 1'b0;
        goto_a(63); lit("swap c63 ack", 32'(a_if.swap_ack), 32'h0);
        goto_a(64); lit("swap c64 ack", 32'(a_if.swap_ack), 32'h1);
                    lit("swap c64 frame_start", 32'(a_if.frame_start), 32'h1);
        goto_a(76); lit("swap c76 row", 32'(a_if.row), 32'h0);
        for (int c = 77; c <= 79; c++) begin
            goto_a(c); lit("swap col3 row", 32'(a_if.row), 32'hA5A5);
        end
        goto_a(80); lit("swap c80 row", 32'(a_if.row), 32'h0);
        goto_a(128); lit("swap c128 ack", 32'(a_if.swap_ack), 32'h0);

        // swap_req held across three frames
        reset_a();
        goto_a(2);  wr_a(4'd3, 16'hA5A5);
        goto_a(3);  a_if.swap_req = 1'b1;
        goto_a(64); lit("hold ack 64", 32'(a_if.swap_ack), 32'h1);
        goto_a(65); lit("hold ack 65", 32'(a_if.swap_ack), 32'h0);
        goto_a(77); lit("hold row 77", 32'(a_if.row), 32'hA5A5);
        goto_a(128); lit("hold ack 128", 32'(a_if.swap_ack), 32'h1);
        goto_a(141); lit("hold row 141", 32'(a_if.row), 32'h0);
        goto_a(192); lit("hold ack 192", 32'(a_if.swap_ack), 32'h1);
        goto_a(200); a_if.swap_req = 1'b0;
        goto_a(205); lit("hold row 205", 32'(a_if.row), 32'hA5A5);

        // write + swap request in the boundary cycle
        reset_a();
        goto_a(63);
        a_if.swap_req = 1'b1;
        wr_a(4'd0, 16'h0001);
        a_if.swap_req = 1'b0;
        goto_a(64); lit("bnd ack 64", 32'(a_if.swap_ack), 32'h0);
                    lit("bnd fs 64", 32'(a_if.frame_start), 32'h1);
        goto_a(65); lit("bnd row 65", 32'(a_if.row), 32'h0);
        goto_a(128); lit("bnd ack 128", 32'(a_if.swap_ack), 32'h1);
        for (int c = 129; c <= 131; c++) begin
            goto_a(c); lit("bnd row col0", 32'(a_if.row), 32'h0001);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
